playseq_sequenciador_preview: RTL



---
 rtl/playseq_sequenciador_preview.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/playseq_sequenciador_preview.sv
// -----------------------------------------------------------------------------
// playseq_sequenciador_preview
//
// Preview player for the PlaySeq game. On a start request it walks the
// sequence RAM from address 0 up to the captured limit, latches each entry,
// lights it on the LEDs for ON_TICKS cycles and then keeps the LEDs dark for
// OFF_TICKS cycles. When the last entry's gap ends it issues a one-cycle
// completion pulse. An abort request jumps straight to the completion state.
//
// Optional feature macro: PREVIEW_BUZZER_EN
//   defined   -> per-colour square-wave tone while an entry is lit
//   undefined -> buzzer held at 0, timing otherwise identical
//
// Ports:
//   clock      game clock (~1 kHz), rising edge
//   reset      synchronous, active-high reset
//   iniciar    start request, only honoured while idle
//   ultimo     index of the last entry to show (captured at start)
//   pular      abort request, honoured while reading/lit/dark
//   dado       RAM read data for endereco (combinational, same cycle)
//   endereco   RAM read address
//   leds       LED drive
//   buzzer     buzzer drive
//   ocupado    busy flag (LE, ACESO, APAGADO, FIM)
//   pronto     one-cycle completion pulse (FIM)
//   db_estado  current state code
// -----------------------------------------------------------------------------
module playseq_sequenciador_preview #(
  parameter int ADDR_W    = 4,
  parameter int ON_TICKS  = 500,
  parameter int OFF_TICKS = 250
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic [ADDR_W-1:0] ultimo,
  input  logic              pular,
  input  logic [3:0]        dado,
  output logic [ADDR_W-1:0] endereco,
  output logic [3:0]        leds,
  output logic              buzzer,
  output logic              ocupado,
  output logic              pronto,
  output logic [2:0]        db_estado
);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    LE      = 3'd1,
    ACESO   = 3'd2,
    APAGADO = 3'd3,
    FIM     = 3'd4
  } estado_t;

  // One timer serves both the lit and the dark phases.
  localparam int TMAX  = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int TMR_W = (TMAX > 1) ? $clog2(TMAX + 1) : 1;
  localparam logic [TMR_W-1:0] ON_LAST  = TMR_W'(ON_TICKS - 1);
  localparam logic [TMR_W-1:0] OFF_LAST = TMR_W'(OFF_TICKS - 1);

  estado_t           estado;
  logic [TMR_W-1:0]  timer;
  logic [3:0]        dreg;
  logic [ADDR_W-1:0] lim;

  assign db_estado = estado;

`ifdef PREVIEW_BUZZER_EN
  // Half-period in cycles chosen by the lowest set bit; 0 means silent.
  function automatic logic [2:0] meio_periodo(input logic [3:0] d);
    logic [2:0] hp;
    if (d[0]) begin
      hp = 3'd2;
    end else if (d[1]) begin
      hp = 3'd3;
    end else if (d[2]) begin
      hp = 3'd4;
    end else if (d[3]) begin
      hp = 3'd5;
    end else begin
      hp = 3'd0;
    end
    return hp;
  endfunction

  logic [2:0] tone_cnt;
  logic [2:0] meio;
  assign meio = meio_periodo(dreg);
`else
  assign buzzer = 1'b0;
`endif

  // Sequencer FSM with registered outputs, address walk and tone generator.
  always_ff @(posedge clock) begin
`ifdef PREVIEW_BUZZER_EN
    // Silent and rewound everywhere except while an entry keeps sounding;
    // this also makes the tone restart from 0 on every ACESO entry.
    buzzer   <= 1'b0;
    tone_cnt <= 3'd0;
`endif
    if (reset) begin
      estado   <= OCIOSO;
      endereco <= {ADDR_W{1'b0}};
      leds     <= 4'd0;
      ocupado  <= 1'b0;
      pronto   <= 1'b0;
      timer    <= {TMR_W{1'b0}};
      dreg     <= 4'd0;
      lim      <= {ADDR_W{1'b0}};
    end else begin
      case (estado)
        OCIOSO: begin
          pronto <= 1'b0;
          leds   <= 4'd0;
          if (iniciar) begin
            estado   <= LE;
            endereco <= {ADDR_W{1'b0}};
            lim      <= ultimo;
            ocupado  <= 1'b1;
          end else begin
            estado  <= OCIOSO;
            ocupado <= 1'b0;
          end
        end

        LE: begin
          timer <= {TMR_W{1'b0}};
          if (pular) begin
            estado <= FIM;
            pronto <= 1'b1;
            leds   <= 4'd0;
          end else begin
            // leds loaded straight from dado so they are lit on the first
            // ACESO cycle together with dreg.
            dreg   <= dado;
            leds   <= dado;
            estado <= ACESO;
          end
        end

        ACESO: begin
          if (pular) begin
            estado <= FIM;
            pronto <= 1'b1;
            leds   <= 4'd0;
          end else if (timer == ON_LAST) begin
            estado <= APAGADO;
            timer  <= {TMR_W{1'b0}};
            leds   <= 4'd0;
          end else begin
            timer <= timer + 1'b1;
            leds  <= dreg;
`ifdef PREVIEW_BUZZER_EN
            if (meio == 3'd0) begin
              buzzer <= 1'b0;
            end else if (tone_cnt == (meio - 3'd1)) begin
              tone_cnt <= 3'd0;
              buzzer   <= ~buzzer;
            end else begin
              tone_cnt <= tone_cnt + 3'd1;
              buzzer   <= buzzer;
            end
`endif
          end
        end

        APAGADO: begin
          leds <= 4'd0;
          if (pular) begin
            estado <= FIM;
            pronto <= 1'b1;
          end else if (timer == OFF_LAST) begin
            timer <= {TMR_W{1'b0}};
            if (endereco == lim) begin
              estado <= FIM;
              pronto <= 1'b1;
            end else begin
              endereco <= endereco + 1'b1;
              estado   <= LE;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        FIM: begin
          estado   <= OCIOSO;
          pronto   <= 1'b0;
          ocupado  <= 1'b0;
          endereco <= {ADDR_W{1'b0}};
          leds     <= 4'd0;
        end

        default: begin
          // Illegal codes recover to idle with quiet outputs.
          estado   <= OCIOSO;
          pronto   <= 1'b0;
          ocupado  <= 1'b0;
          endereco <= {ADDR_W{1'b0}};
          leds     <= 4'd0;
          timer    <= {TMR_W{1'b0}};
        end
      endcase
    end
  end

endmodule
